// File: rtl/dbus_arbiter_if.sv
// Shared data-bus handshake: one-cycle bstart with breq held until the target returns bdone.
// The master side issues requests and their attributes; the slave side returns bdone and rdata.
interface master_bus_if;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TTYPE_W = 2;
    localparam int unsigned TSIZE_W = 2;

    logic               breq;
    logic               bstart;
    logic               bdone;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic [TTYPE_W-1:0] ttype;
    logic [TSIZE_W-1:0] tsize;

    modport master (
        output breq, bstart, addr, wdata, ttype, tsize,
        input  bdone, rdata
    );

    modport slave (
        input  breq, bstart, addr, wdata, ttype, tsize,
        output bdone, rdata
    );
endinterface

// File: rtl/dbus_arbiter.sv
// Arbitrates the core load/store port and the debug SBA master onto one downstream bus,
// with a per-transaction watchdog. Define DBUS_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module dbus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    master_bus_if.slave  core,
    master_bus_if.slave  dbg,
    master_bus_if.master mem,
    output logic         grant_dbg,
    output logic         busy,
    output logic         timeout_err
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]      ABORT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           winner_c;
    logic             pend_core_q, pend_core_d;
    logic             pend_dbg_q, pend_dbg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
    owner_e           last_q, last_d;
`endif

    logic        active_c;
    logic        abort_c;
    logic        done_c;
    logic        core_done_c;
    logic        dbg_done_c;
    logic        sel_dbg_c;
    logic [31:0] rdata_c;

    // Winner among pending requesters; debug wins ties unless round-robin is built.
    always_comb begin
        winner_c = pend_dbg_q ? OWN_DBG : OWN_CORE;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
        if (pend_dbg_q && pend_core_q) begin
            winner_c = (last_q == OWN_CORE) ? OWN_DBG : OWN_CORE;
        end
`endif
    end

    // A downstream bdone takes precedence over a watchdog expiry in the same cycle.
    assign active_c    = (state_q != ST_IDLE);
    assign abort_c     = (state_q == ST_WAIT) && !mem.bdone && (cnt_q == CNT_LIMIT);
    assign done_c      = active_c && (mem.bdone || abort_c);
    assign core_done_c = done_c && (owner_q == OWN_CORE);
    assign dbg_done_c  = done_c && (owner_q == OWN_DBG);
    assign rdata_c     = abort_c ? ABORT_RDATA : mem.rdata;

    assign core.bdone = core_done_c;
    assign dbg.bdone  = dbg_done_c;
    assign core.rdata = (active_c && (owner_q == OWN_CORE)) ? rdata_c : '0;
    assign dbg.rdata  = (active_c && (owner_q == OWN_DBG))  ? rdata_c : '0;

    // Attributes are muxed live; requesters keep them stable until their bdone.
    assign sel_dbg_c  = active_c ? (owner_q == OWN_DBG) : pend_dbg_q;
    assign mem.breq   = active_c;
    assign mem.bstart = (state_q == ST_ISSUE);
    assign mem.addr   = sel_dbg_c ? dbg.addr  : core.addr;
    assign mem.wdata  = sel_dbg_c ? dbg.wdata : core.wdata;
    assign mem.ttype  = sel_dbg_c ? dbg.ttype : core.ttype;
    assign mem.tsize  = sel_dbg_c ? dbg.tsize : core.tsize;

    assign grant_dbg   = active_c && (owner_q == OWN_DBG);
    assign busy        = active_c;
    assign timeout_err = abort_c;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_core_q || pend_dbg_q) begin
                    owner_d = winner_c;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = mem.bdone ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != CNT_LIMIT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (done_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A bstart in the owner's completion cycle re-arms the flag: set wins over clear.
    always_comb begin
        pend_core_d = (core.bstart && core.breq && (!pend_core_q || core_done_c))
                    || (pend_core_q && !core_done_c);
        pend_dbg_d  = (dbg.bstart && dbg.breq && (!pend_dbg_q || dbg_done_c))
                    || (pend_dbg_q && !dbg_done_c);
    end

`ifdef DBUS_ARB_ROUND_ROBIN_EN
    assign last_d = done_c ? owner_q : last_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CORE;
            pend_core_q <= 1'b0;
            pend_dbg_q  <= 1'b0;
            cnt_q       <= '0;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
            last_q      <= OWN_CORE;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            pend_core_q <= pend_core_d;
            pend_dbg_q  <= pend_dbg_d;
            cnt_q       <= cnt_d;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a timestamp-based transaction model.
module tb_dbus_arbiter;
    localparam int unsigned TO    = 4;
    localparam int          NEVER = 1000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    master_bus_if core_if ();
    master_bus_if dbg_if ();
    master_bus_if mem_if ();

    logic grant_dbg, busy, timeout_err;

    dbus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .core       (core_if),
        .dbg        (dbg_if),
        .mem        (mem_if),
        .grant_dbg  (grant_dbg),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // Requester side: index 0 = core, 1 = debug
    logic        req_bstart [2];
    logic        req_breq   [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [1:0]  req_ttype  [2];
    logic [1:0]  req_tsize  [2];
    logic        req_bd     [2];
    logic [31:0] req_rd     [2];
    bit          out_r      [2];

    assign core_if.bstart = req_bstart[0];
    assign core_if.breq   = req_breq[0];
    assign core_if.addr   = req_addr[0];
    assign core_if.wdata  = req_wdata[0];
    assign core_if.ttype  = req_ttype[0];
    assign core_if.tsize  = req_tsize[0];
    assign dbg_if.bstart  = req_bstart[1];
    assign dbg_if.breq    = req_breq[1];
    assign dbg_if.addr    = req_addr[1];
    assign dbg_if.wdata   = req_wdata[1];
    assign dbg_if.ttype   = req_ttype[1];
    assign dbg_if.tsize   = req_tsize[1];
    assign req_bd[0] = core_if.bdone;
    assign req_bd[1] = dbg_if.bdone;
    assign req_rd[0] = core_if.rdata;
    assign req_rd[1] = dbg_if.rdata;

    // Downstream slave stimulus
    logic        s_bdone;
    logic [31:0] s_rdata;
    int          lat_cfg;
    logic [31:0] rd_cfg;
    bit          rand_mode;
    int          stray_req;
    int          stray_done;
    int          s_cnt;

    assign mem_if.bdone = s_bdone;
    assign mem_if.rdata = s_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Slave: bdone lat_cfg cycles after mem.bstart (negative = random), optional strays
    initial begin
        s_bdone    = 1'b0;
        s_rdata    = '0;
        s_cnt      = -1;
        stray_done = 0;
        forever begin
            @(posedge clk);
            #1;
            s_bdone = 1'b0;
            if (rst) begin
                s_cnt = -1;
            end else begin
                if (mem_if.bstart)
                    s_cnt = (lat_cfg < 0) ? int'($urandom_range(0, 7)) : lat_cfg;
                if (stray_req != stray_done) begin
                    stray_done = stray_req;
                    s_bdone    = 1'b1;
                    s_rdata    = 32'hBAD0_0001;
                end else if (s_cnt == 0) begin
                    s_bdone = 1'b1;
                    s_rdata = (lat_cfg < 0) ? $urandom : rd_cfg;
                    s_cnt   = -1;
                end else begin
                    if (s_cnt > 0) s_cnt--;
                    if (rand_mode && !mem_if.breq && $urandom_range(0, 15) == 0) begin
                        s_bdone = 1'b1;
                        s_rdata = $urandom;
                    end
                end
            end
        end
    end

    // Transaction model: an in-flight transfer is an owner plus the cycle it was issued.
    int          cyc = 0;
    bit          m_busy, m_own, m_last, m_issue, m_abort, m_done, m_sel;
    bit          m_pend [2];
    bit          m_op   [2];
    bit          m_bd   [2];
    int          m_t0;
    logic [31:0] m_rd;

    initial begin
        m_busy = 0; m_own = 0; m_last = 0; m_t0 = 0;
        m_pend[0] = 0; m_pend[1] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_grant_dbg", grant_dbg, 1'b0);
                chk1("rst_mem_breq", mem_if.breq, 1'b0);
                chk1("rst_mem_bstart", mem_if.bstart, 1'b0);
                chk1("rst_timeout_err", timeout_err, 1'b0);
                chk1("rst_core_bdone", req_bd[0], 1'b0);
                chk1("rst_dbg_bdone", req_bd[1], 1'b0);
                m_busy = 0; m_own = 0; m_last = 0;
                m_pend[0] = 0; m_pend[1] = 0;
            end else begin
                m_issue = m_busy && (cyc == m_t0);
                m_abort = m_busy && !m_issue && !s_bdone && (cyc - m_t0 == int'(TO) + 1);
                m_done  = m_busy && (s_bdone || m_abort);
                m_bd[0] = m_done && !m_own;
                m_bd[1] = m_done && m_own;
                m_rd    = m_abort ? 32'hDEAD_BEEF : s_rdata;
                chk1("busy", busy, m_busy);
                chk1("grant_dbg", grant_dbg, m_busy && m_own);
                chk1("mem_breq", mem_if.breq, m_busy);
                chk1("mem_bstart", mem_if.bstart, m_issue);
                chk1("timeout_err", timeout_err, m_abort);
                chk1("core_bdone", req_bd[0], m_bd[0]);
                chk1("dbg_bdone", req_bd[1], m_bd[1]);
                if (m_done) chk("owner_rdata", req_rd[m_own], m_rd);
                if (m_busy) chk("nonowner_rdata", req_rd[!m_own], 32'h0);
                m_sel = m_busy ? m_own : m_pend[1];
                chk("mem_addr", mem_if.addr, req_addr[m_sel]);
                chk("mem_wdata", mem_if.wdata, req_wdata[m_sel]);
                chk("mem_ttype", 32'(mem_if.ttype), 32'(req_ttype[m_sel]));
                chk("mem_tsize", 32'(mem_if.tsize), 32'(req_tsize[m_sel]));

                m_op[0] = m_pend[0];
                m_op[1] = m_pend[1];
                if (m_done) begin
                    m_pend[m_own] = 0;
                    m_last = m_own;
                    m_busy = 0;
                end else if (!m_busy && (m_op[0] || m_op[1])) begin
`ifdef DBUS_ARB_ROUND_ROBIN_EN
                    m_own = (m_op[0] && m_op[1]) ? !m_last : m_op[1];
`else
                    m_own = m_op[1];
`endif
                    m_busy = 1;
                    m_t0   = cyc + 1;
                end
                for (int r = 0; r < 2; r++)
                    if (req_bstart[r] && req_breq[r] && (!m_op[r] || m_bd[r])) m_pend[r] = 1;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        for (int r = 0; r < 2; r++) begin
            req_bstart[r] = 1'b0;
            if (out_r[r] && req_bd[r]) begin
                out_r[r]    = 0;
                req_breq[r] = 1'b0;
            end
        end
    endtask

    task automatic start(input int r, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] tt, input logic [1:0] ts);
        req_addr[r]   = a;
        req_wdata[r]  = wd;
        req_ttype[r]  = tt;
        req_tsize[r]  = ts;
        req_bstart[r] = 1'b1;
        req_breq[r]   = 1'b1;
        out_r[r]      = 1;
    endtask

    logic ord_q [$];
    logic ord_v;

    initial begin
        rst = 1'b1;
        lat_cfg = 3; rd_cfg = 32'h1234_5678; rand_mode = 0; stray_req = 0;
        for (int r = 0; r < 2; r++) begin
            req_bstart[r] = 0; req_breq[r] = 0; req_addr[r] = '0; req_wdata[r] = '0;
            req_ttype[r] = '0; req_tsize[r] = '0; out_r[r] = 0;
        end
        step(); step();
        rst = 1'b0;
        step(); #1;
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_grant_dbg", grant_dbg, 1'b0);
        chk1("idle_mem_breq", mem_if.breq, 1'b0);

        // Single core read, 3-cycle slave
        step();
        start(0, 32'h8000_0010, 32'h0, 2'b00, 2'b10);
        step(); #1;
        chk1("rd_not_yet_issued", mem_if.bstart, 1'b0);
        step(); #1;
        chk1("rd_issue_at_n2", mem_if.bstart, 1'b1);
        chk("rd_issue_addr", mem_if.addr, 32'h8000_0010);
        step(); step(); step(); #1;
        chk1("rd_core_bdone", req_bd[0], 1'b1);
        chk("rd_core_rdata", req_rd[0], 32'h1234_5678);
        chk1("rd_dbg_bdone_quiet", req_bd[1], 1'b0);

        // Same-cycle collision, zero-wait slave
        step(); step();
        lat_cfg = 0; rd_cfg = 32'hCAFE_0001;
        start(0, 32'h0000_1000, 32'h1111_1111, 2'b01, 2'b10);
        start(1, 32'h0000_2000, 32'h2222_2222, 2'b01, 2'b10);
        step(); step(); #1;
        chk1("col_first_issue", mem_if.bstart, 1'b1);
        chk1("col_first_grant_dbg", grant_dbg, 1'b1);
        chk1("col_first_dbg_bdone", req_bd[1], 1'b1);
        step(); #1;
        chk1("col_gap_idle", busy, 1'b0);
        step(); #1;
        chk1("col_second_issue", mem_if.bstart, 1'b1);
        chk1("col_second_grant_dbg", grant_dbg, 1'b0);
        chk1("col_second_core_bdone", req_bd[0], 1'b1);

        // Three collisions in a row: owner order alternates dbg, core
        for (int k = 0; k < 3; k++) begin
            step();
            start(0, 32'h0000_3000 + 32'(k), 32'h0, 2'b00, 2'b00);
            start(1, 32'h0000_4000 + 32'(k), 32'h0, 2'b00, 2'b00);
            for (int c = 0; c < 5; c++) begin
                step(); #1;
                if (mem_if.bstart) ord_q.push_back(grant_dbg);
            end
        end
        chk("col3_issue_count", 32'(ord_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            ord_v = (i < ord_q.size()) ? ord_q[i] : 1'bx;
            chk1("col3_owner_order", ord_v, (i % 2) == 0);
        end

        // Watchdog abort with a never-responding slave, then a late stray bdone
        step();
        lat_cfg = NEVER;
        start(0, 32'h0000_5000, 32'h0, 2'b00, 2'b10);
        step(); step(); #1;
        chk1("to_issue", mem_if.bstart, 1'b1);
        step(); step(); step(); step(); #1;
        chk1("to_not_yet", timeout_err, 1'b0);
        step(); #1;
        chk1("to_timeout_err", timeout_err, 1'b1);
        chk1("to_core_bdone", req_bd[0], 1'b1);
        chk("to_core_rdata", req_rd[0], 32'hDEAD_BEEF);
        chk1("to_dbg_bdone_quiet", req_bd[1], 1'b0);
        step(); #1;
        chk1("to_back_idle", busy, 1'b0);
        stray_req++;
        step(); #1;
        chk1("stray_core_bdone", req_bd[0], 1'b0);
        chk1("stray_dbg_bdone", req_bd[1], 1'b0);
        chk1("stray_busy", busy, 1'b0);

        // Reset while waiting on the slave
        step();
        start(0, 32'h0000_6000, 32'h0, 2'b00, 2'b10);
        step(); step(); step(); #1;
        chk1("rw_in_wait", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rw_busy_drop", busy, 1'b0);
        chk1("rw_breq_drop", mem_if.breq, 1'b0);
        chk1("rw_core_bdone", req_bd[0], 1'b0);
        for (int r = 0; r < 2; r++) begin
            out_r[r] = 0; req_breq[r] = 1'b0;
        end
        step();
        rst = 1'b0;
        step(); #1;
        chk1("rw_no_reissue", busy, 1'b0);
        lat_cfg = 1; rd_cfg = 32'h0BAD_F00D;
        step();
        start(1, 32'h0000_7000, 32'h7777_7777, 2'b01, 2'b01);
        step(); step(); #1;
        chk1("rw_dbg_issue", mem_if.bstart, 1'b1);
        chk1("rw_dbg_grant", grant_dbg, 1'b1);
        step(); #1;
        chk1("rw_dbg_bdone", req_bd[1], 1'b1);
        chk("rw_dbg_rdata", req_rd[1], 32'h0BAD_F00D);

        // Re-request in the same cycle as the completion
        step();
        lat_cfg = 2;
        start(0, 32'h0000_8000, 32'h0, 2'b00, 2'b10);
        step(); step(); step(); step();
        chk1("rr_first_bdone", req_bd[0], 1'b1);
        start(0, 32'h0000_8004, 32'h0, 2'b00, 2'b10);
        step(); #1;
        chk1("rr_gap_idle", busy, 1'b0);
        step(); #1;
        chk1("rr_second_issue", mem_if.bstart, 1'b1);
        chk1("rr_second_owner_core", grant_dbg, 1'b0);
        chk("rr_second_addr", mem_if.addr, 32'h0000_8004);

        // Randomized traffic
        lat_cfg = -1; rand_mode = 1;
        repeat (4000) begin
            step();
            for (int r = 0; r < 2; r++) begin
                if (!out_r[r]) begin
                    if ($urandom_range(0, 3) == 0)
                        start(r, $urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_bstart[r] = 1'b1;
                end
            end
        end
        rand_mode = 0; lat_cfg = 1;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
